// File: rtl/v_pack_pkg.sv
// v_pack_pkg: shared widths, defaults and state constants for v_pack_unit
package v_pack_pkg;
  localparam int VEC_W = 64;
  localparam int HALF_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W = 16;
  typedef logic [1:0] state_t;
  localparam state_t LO = 2'd0;
  localparam state_t HI = 2'd1;
  localparam state_t WR = 2'd2;
endpackage

// File: rtl/v_pack_unit.sv
// v_pack_unit: packs two 32-bit GPR beats into one vector regfile write; V_PACK_SPLAT_EN enables one-beat splat
module v_pack_unit
  import v_pack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_splat,
  input  logic              flush,
  input  logic              port_busy,
  output logic              from_GPR,
  output logic              D_En,
  output logic [ADDR_W-1:0] D_Addrs,
  output logic [VEC_W-1:0]  GPR_DATA,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);
  state_t state;
  logic accept;
  logic splat;
`ifdef V_PACK_SPLAT_EN
  assign splat = in_splat;
`else
  logic unused_splat;
  assign unused_splat = in_splat;
  assign splat = 1'b0;
`endif
  // handshake and write-strobe decode; flush suppresses both beat capture and the write
  always_comb begin
    in_ready = (state == LO) || (state == HI);
    busy = state != LO;
    from_GPR = state == WR;
    D_En = from_GPR && !port_busy && !flush;
    accept = in_valid && in_ready && !flush;
  end
  // sequencer: capture low beat and address, then high beat, then retire on the write cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LO;
      GPR_DATA <= '0;
      D_Addrs <= '0;
      wr_count <= '0;
    end else if (flush) begin
      state <= LO;
    end else if (accept && state == LO) begin
      GPR_DATA <= splat ? {in_data, in_data} : {GPR_DATA[VEC_W-1:HALF_W], in_data};
      D_Addrs <= in_addr;
      state <= splat ? WR : HI;
    end else if (accept) begin
      GPR_DATA[VEC_W-1:HALF_W] <= in_data;
      state <= WR;
    end else if (D_En) begin
      state <= LO;
      wr_count <= wr_count + 1'b1;
    end
  end
endmodule

// File: doc/v_pack_unit.md
# v_pack_unit

GPR-to-vector transfer sequencer. It accepts 32-bit words from the scalar datapath over a valid/ready handshake and assembles low-then-high beats into one 64-bit vector word. It then issues a single write into the vector register file through that file's GPR write path (from_GPR / D_En / D_Addrs / GPR_DATA). It is the inbound counterpart of the vector unit's 32-bit hi/lo readout to the GPR.

## Interface
Parameters:
- ADDR_W, 5, vector register address width
- CNT_W, 16, width of the write counter

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  source presents a 32-bit beat
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  32  beat payload
- in_addr  in  ADDR_W  destination vector register; sampled on the low beat only
- in_splat  in  1  replicate request; sampled on the low beat; ignored unless V_PACK_SPLAT_EN
- flush  in  1  synchronous abort of any partial or pending transfer
- port_busy  in  1  vector regfile write port occupied by the ALU this cycle
- from_GPR  out  1  regfile data-source select: GPR path
- D_En  out  1  regfile write strobe
- D_Addrs  out  ADDR_W  regfile write address
- GPR_DATA  out  64  assembled vector word
- busy  out  1  a transfer is in progress (state != LO)
- wr_count  out  CNT_W  number of completed vector writes, wraps modulo 2^CNT_W

## Operation
- FSM states: LO (await low beat), HI (await high beat), WR (write pending).
- Beat accepted when in_valid & in_ready. in_ready = (state == LO) | (state == HI).
- LO, accept: GPR_DATA[31:0] <= in_data, D_Addrs <= in_addr, go to HI.
- HI, accept: GPR_DATA[63:32] <= in_data, go to WR. in_addr ignored.
- WR: from_GPR = 1. D_En = ~port_busy (combinational). While port_busy, hold WR with data and address stable. On the write cycle (D_En = 1): go to LO and increment wr_count.
- flush has priority over all transitions. Next state is LO, wr_count is unchanged, and any beat presented that cycle is dropped. In WR, flush forces D_En = 0 that cycle.
- GPR_DATA and D_Addrs keep their last values after the write. They are only meaningful while from_GPR = 1.
- No backpressure on the write side other than port_busy. No queueing: one vector in flight.

## Timing
- Reset values: state LO, in_ready 1, busy 0, from_GPR 0, D_En 0, D_Addrs 0, GPR_DATA 0, wr_count 0.
- Reset is asynchronous; asserting it mid-transfer discards the transfer immediately with no write.
- Best-case sequence: low beat accepted cycle n, high beat n+1, D_En high cycle n+2. Peak throughput is one vector per 3 cycles.
- Each cycle port_busy is high in WR adds one cycle of latency.
- in_valid low in LO or HI holds the state indefinitely; there is no timeout.
- wr_count wraps from 2^CNT_W−1 to 0.
- Simultaneous flush and write-eligible WR (port_busy low): flush wins, no write.

## Configuration
- Macro: V_PACK_SPLAT_EN.
- Defined: a low beat accepted with in_splat = 1 loads in_data into both halves, captures in_addr, and goes directly LO→WR. Write occurs the next cycle (2-cycle best case).
- Undefined: in_splat is ignored and every transfer takes two beats. The port remains present so the top-level connection is unchanged.

## Structure
- Shared package v_pack_pkg holds:
  - the state enum (LO/HI/WR);
  - VEC_W = 64 and HALF_W = 32;
  - default ADDR_W and CNT_W.
- Single module; no sub-module is warranted.
- The write-counter can remain inline.

## Test plan
- Basic pack: beats 0x1111_2222 (addr 7), then 0x3333_4444 with port_busy = 0 → one cycle later D_En = 1, D_Addrs = 7, GPR_DATA = 0x3333_4444_1111_2222, wr_count = 1.
- Write-port stall: same transfer with port_busy high for 3 cycles in WR → D_En stays 0 and in_ready stays 0 throughout. Write occurs on the first port_busy-low cycle with data unchanged.
- Flush: flush asserted in HI after a low beat → state LO, no D_En. The next two beats 0xA/0xB to addr 3 produce GPR_DATA = 0x0000_000B_0000_000A and wr_count unchanged until that write.
- Reset mid-transfer: reset asserted in WR between clock edges → all outputs return to reset values immediately, and no write occurs after release.
- Splat (V_PACK_SPLAT_EN defined): low beat 0xDEAD_BEEF, in_splat = 1, addr 31 → next cycle D_En = 1, GPR_DATA = 0xDEAD_BEEF_DEAD_BEEF. With the macro undefined, the same stimulus waits in HI.
- Counter wrap (CNT_W = 4): 17 back-to-back transfers → wr_count reads 1.
